// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: 16 GPRs, HI/LO, PC, IR, Y, 64-bit Z, MAR, MDR, in-port, C constant and ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier/divider; without it Mul/Div produce 0.
module datapath (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] gpr_in,
  input  logic [15:0] gpr_out,
  input  logic        hi_in,
  input  logic        lo_in,
  input  logic        hi_out,
  input  logic        lo_out,
  input  logic        pc_in,
  input  logic        pc_out,
  input  logic        ir_in,
  input  logic        z_in,
  input  logic        z_high_out,
  input  logic        z_low_out,
  input  logic        inport_out,
  input  logic        c_out,
  input  logic        y_in,
  input  logic        mar_in,
  input  logic        mdr_in,
  input  logic        mdr_out,
  input  logic        read,
  input  logic [31:0] m_data_in,
  input  logic [3:0]  alu_op,
  input  logic        inc_pc,
  output logic [31:0] bus_data
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_ROR  = 4'b0110;
  localparam logic [3:0] OP_ROL  = 4'b0111;
  localparam logic [3:0] OP_NEG  = 4'b1010;
  localparam logic [3:0] OP_NOT  = 4'b1011;
  localparam logic [3:0] OP_SHRA = 4'b1100;
`ifdef DATAPATH_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
`endif

  logic [31:0] gpr [16];
  logic [31:0] hi, lo, pc, ir, y, mar, mdr, inport;
  logic [63:0] z;
  logic [31:0] c_value;
  logic [63:0] alu_result;
  logic [31:0] res32;
  logic [4:0]  shamt;
  logic [5:0]  shamt_inv;
  logic        bus_claimed;
  logic        unused_bits;

  assign c_value   = {{13{ir[18]}}, ir[18:0]};
  assign shamt     = bus_data[4:0];
  assign shamt_inv = 6'd32 - {1'b0, shamt};
  // MAR feeds only the external memory address path, and IR[31:19] only the control unit.
  assign unused_bits = ^{mar, ir[31:19]};

  // Priority bus mux: lowest-index GPR wins, then HI, LO, Z_high, Z_low, PC, MDR, InPort, C.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    bus_data    = '0;
    bus_claimed = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!bus_claimed && gpr_out[i]) begin
        bus_data    = gpr[i];
        bus_claimed = 1'b1;
      end
    end
    if (!bus_claimed) begin
      if      (hi_out)     bus_data = hi;
      else if (lo_out)     bus_data = lo;
      else if (z_high_out) bus_data = z[63:32];
      else if (z_low_out)  bus_data = z[31:0];
      else if (pc_out)     bus_data = pc;
      else if (mdr_out)    bus_data = mdr;
      else if (inport_out) bus_data = inport;
      else if (c_out)      bus_data = c_value;
    end
  end

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] a_ext, b_ext;
  logic signed [31:0] quot, rem;
`endif

  // ALU: A = Y, B = bus. 32-bit ops zero-extend into the 64-bit result.
  always_comb begin
    res32      = '0;
    alu_result = '0;
`ifdef DATAPATH_MULDIV_EN
    a_ext = {{32{y[31]}}, y};
    b_ext = {{32{bus_data[31]}}, bus_data};
    quot  = '0;
    rem   = '0;
`endif
    if (inc_pc) begin
      alu_result = {32'd0, bus_data + 32'd1};
    end else begin
      case (alu_op)
        OP_AND:  res32 = y & bus_data;
        OP_OR:   res32 = y | bus_data;
        OP_ADD:  res32 = y + bus_data;
        OP_SUB:  res32 = y - bus_data;
        OP_SHR:  res32 = y >> shamt;
        OP_SHL:  res32 = y << shamt;
        OP_ROR:  res32 = (y >> shamt) | (y << shamt_inv);
        OP_ROL:  res32 = (y << shamt) | (y >> shamt_inv);
        OP_NEG:  res32 = 32'd0 - bus_data;
        OP_NOT:  res32 = ~bus_data;
        OP_SHRA: res32 = $signed(y) >>> shamt;
        default: res32 = '0;
      endcase
      alu_result = {32'd0, res32};
`ifdef DATAPATH_MULDIV_EN
      if (alu_op == OP_MUL) begin
        alu_result = a_ext * b_ext;
      end else if (alu_op == OP_DIV) begin
        // Zero divisor yields 0; the one overflowing quotient is pinned explicitly.
        if (bus_data == 32'd0) begin
          alu_result = '0;
        end else if (y == 32'h8000_0000 && bus_data == 32'hFFFF_FFFF) begin
          alu_result = {32'd0, 32'h8000_0000};
        end else begin
          quot       = $signed(y) / $signed(bus_data);
          rem        = $signed(y) % $signed(bus_data);
          alu_result = {rem, quot};
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the register file is reset like any other register, so it cannot map onto a RAM macro.
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      hi     <= '0;
      lo     <= '0;
      pc     <= '0;
      ir     <= '0;
      y      <= '0;
      z      <= '0;
      mar    <= '0;
      mdr    <= '0;
      inport <= '0;
    end else begin
      // NOTE: non-blocking loads let a register drive the bus and capture a new value in the same cycle.
      for (int i = 0; i < 16; i++) begin
        if (gpr_in[i]) gpr[i] <= bus_data;
      end
      if (hi_in)  hi  <= bus_data;
      if (lo_in)  lo  <= bus_data;
      if (pc_in)  pc  <= bus_data;
      if (ir_in)  ir  <= bus_data;
      if (y_in)   y   <= bus_data;
      if (z_in)   z   <= alu_result;
      if (mar_in) mar <= bus_data;
      if (mdr_in) mdr <= read ? m_data_in : bus_data;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: register transfers, ALU ops, bus priority and async reset.
// Mul/Div expectations follow DATAPATH_MULDIV_EN.
module tb_datapath;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] gpr_in, gpr_out;
  logic        hi_in, lo_in, hi_out, lo_out, pc_in, pc_out, ir_in, z_in;
  logic        z_high_out, z_low_out, inport_out, c_out, y_in, mar_in;
  logic        mdr_in, mdr_out, read, inc_pc;
  logic [31:0] m_data_in;
  logic [3:0]  alu_op;
  logic [31:0] bus_data;

  int n_asserts = 0;
  int n_fails   = 0;

  localparam logic [3:0] AND_OP = 4'b0000, OR_OP = 4'b0001, ADD_OP = 4'b0010, SUB_OP = 4'b0011;
  localparam logic [3:0] SHR_OP = 4'b0100, SHL_OP = 4'b0101, ROR_OP = 4'b0110, ROL_OP = 4'b0111;
  localparam logic [3:0] MUL_OP = 4'b1000, DIV_OP = 4'b1001, NEG_OP = 4'b1010, NOT_OP = 4'b1011;
  localparam logic [3:0] SHRA_OP = 4'b1100, RSV_OP = 4'b1101;

  datapath dut (
    .clk(clk), .reset_n(reset_n), .gpr_in(gpr_in), .gpr_out(gpr_out),
    .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .pc_in(pc_in), .pc_out(pc_out), .ir_in(ir_in), .z_in(z_in),
    .z_high_out(z_high_out), .z_low_out(z_low_out), .inport_out(inport_out),
    .c_out(c_out), .y_in(y_in), .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .read(read), .m_data_in(m_data_in), .alu_op(alu_op), .inc_pc(inc_pc),
    .bus_data(bus_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    gpr_in = '0; gpr_out = '0;
    hi_in = 0; lo_in = 0; hi_out = 0; lo_out = 0; pc_in = 0; pc_out = 0;
    ir_in = 0; z_in = 0; z_high_out = 0; z_low_out = 0; inport_out = 0;
    c_out = 0; y_in = 0; mar_in = 0; mdr_in = 0; mdr_out = 0; read = 0;
    inc_pc = 0; m_data_in = '0; alu_op = '0;
  endtask

  task automatic put_mdr(input logic [31:0] v);
    idle();
    read = 1; mdr_in = 1; m_data_in = v;
    tick();
    idle();
  endtask

  task automatic load_gpr(input string tag, input int idx, input logic [31:0] v);
    put_mdr(v);
    mdr_out = 1; gpr_in[idx] = 1'b1;
    #1 check(tag, bus_data, v);
    tick();
    idle();
  endtask

  task automatic expect_gpr(input string tag, input int idx, input logic [31:0] exp);
    idle();
    gpr_out[idx] = 1'b1;
    #1 check(tag, bus_data, exp);
    idle();
  endtask

  task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic inc);
    put_mdr(a);
    mdr_out = 1; y_in = 1;
    tick();
    put_mdr(b);
    mdr_out = 1; alu_op = op; inc_pc = inc; z_in = 1;
    tick();
    idle();
  endtask

  task automatic expect_z(input string tag, input logic [63:0] exp);
    idle();
    z_low_out = 1;
    #1 check({tag, "_lo"}, bus_data, exp[31:0]);
    idle();
    z_high_out = 1;
    #1 check({tag, "_hi"}, bus_data, exp[63:32]);
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    #12;
    check("reset_bus_idle", bus_data, 32'h0);
    gpr_out[7] = 1'b1;
    #1 check("reset_r7", bus_data, 32'h0);
    idle();
    reset_n = 1'b1;

    // Memory data into GPRs via MDR
    load_gpr("mdr_to_r2_bus", 2, 32'h22);
    expect_gpr("r2", 2, 32'h22);
    load_gpr("mdr_to_r4_bus", 4, 32'h24);
    expect_gpr("r4", 4, 32'h24);
    load_gpr("mdr_to_r5_bus", 5, 32'hFF);
    expect_gpr("r5", 5, 32'hFF);

    // Instruction fetch: PC -> MAR, Z = PC+1, PC <= Z, MDR <= memory, IR <= MDR
    idle();
    pc_out = 1; mar_in = 1; inc_pc = 1; z_in = 1; alu_op = ADD_OP;
    #1 check("fetch_pc_on_bus", bus_data, 32'h0);
    tick(); idle();
    z_low_out = 1; pc_in = 1; read = 1; mdr_in = 1; m_data_in = 32'h8290_0000;
    #1 check("fetch_zlow_pc_plus1", bus_data, 32'h1);
    tick(); idle();
    pc_out = 1;
    #1 check("fetch_pc_now_1", bus_data, 32'h1);
    idle();
    mdr_out = 1; ir_in = 1;
    #1 check("fetch_mdr", bus_data, 32'h8290_0000);
    tick(); idle();
    c_out = 1;
    #1 check("c_from_ir_8290", bus_data, 32'h0);
    idle();
    pc_out = 1; inc_pc = 1; z_in = 1;
    tick(); idle();
    z_low_out = 1; pc_in = 1;
    tick(); idle();
    pc_out = 1;
    #1 check("pc_now_2", bus_data, 32'h2);
    idle();

    // C constant sign extension of IR[18:0]
    put_mdr(32'h0004_0005);
    mdr_out = 1; ir_in = 1; tick(); idle();
    c_out = 1;
    #1 check("c_negative", bus_data, 32'hFFFC_0005);
    put_mdr(32'hFFF3_ABCD);
    mdr_out = 1; ir_in = 1; tick(); idle();
    c_out = 1;
    #1 check("c_positive", bus_data, 32'h0003_ABCD);
    idle();

    // Neg of R2 into R5
    gpr_out[2] = 1'b1; alu_op = NEG_OP; z_in = 1;
    tick(); idle();
    z_low_out = 1; gpr_in[5] = 1'b1;
    #1 check("neg_transfer_bus", bus_data, 32'hFFFF_FFDE);
    tick(); idle();
    expect_gpr("r5_neg", 5, 32'hFFFF_FFDE);
    z_high_out = 1;
    #1 check("neg_zhigh_zero", bus_data, 32'h0);
    idle();

    // ALU operations
    alu_run(32'hF0F0_1234, 32'hFF00_FF00, AND_OP, 1'b0); expect_z("and", 64'h0000_0000_F000_1200);
    alu_run(32'hF0F0_1234, 32'hFF00_FF00, OR_OP,  1'b0); expect_z("or",  64'h0000_0000_FFF0_FF34);
    alu_run(32'hFFFF_FFFF, 32'h0000_0002, ADD_OP, 1'b0); expect_z("add_wrap", 64'h1);
    alu_run(32'h0000_0005, 32'h0000_0007, SUB_OP, 1'b0); expect_z("sub_wrap", 64'h0000_0000_FFFF_FFFE);
    alu_run(32'h8000_0001, 32'h1, SHR_OP,  1'b0); expect_z("shr",  64'h0000_0000_4000_0000);
    alu_run(32'h8000_0001, 32'h1, SHRA_OP, 1'b0); expect_z("shra", 64'h0000_0000_C000_0000);
    alu_run(32'h8000_0001, 32'h1, ROR_OP,  1'b0); expect_z("ror",  64'h0000_0000_C000_0000);
    alu_run(32'h8000_0001, 32'h1, ROL_OP,  1'b0); expect_z("rol",  64'h3);
    alu_run(32'h8000_0001, 32'h21, SHL_OP, 1'b0); expect_z("shl_b4_0", 64'h2);
    alu_run(32'h8000_0001, 32'h0, SHL_OP,  1'b0); expect_z("shl_by0", 64'h0000_0000_8000_0001);
    alu_run(32'h1234_5678, 32'h20, ROR_OP, 1'b0); expect_z("ror_by0", 64'h0000_0000_1234_5678);
    alu_run(32'h1234_5678, 32'h0, NOT_OP,  1'b0); expect_z("not0", 64'h0000_0000_FFFF_FFFF);
    alu_run(32'h1234_5678, 32'h5, RSV_OP,  1'b0); expect_z("reserved", 64'h0);
    alu_run(32'h0000_0100, 32'h41, SUB_OP, 1'b1); expect_z("inc_pc_override", 64'h42);
`ifdef DATAPATH_MULDIV_EN
    alu_run(32'h22, 32'h24, MUL_OP, 1'b0); expect_z("mul", 64'h4C8);
    alu_run(32'hFFFF_FFFE, 32'h3, MUL_OP, 1'b0); expect_z("mul_signed", 64'hFFFF_FFFF_FFFF_FFFA);
    alu_run(32'h24, 32'h22, DIV_OP, 1'b0); expect_z("div", 64'h0000_0002_0000_0001);
    alu_run(32'hFFFF_FFF9, 32'h2, DIV_OP, 1'b0); expect_z("div_neg", 64'hFFFF_FFFF_FFFF_FFFD);
    alu_run(32'h24, 32'h0, DIV_OP, 1'b0); expect_z("div_by0", 64'h0);
    alu_run(32'h8000_0000, 32'hFFFF_FFFF, DIV_OP, 1'b0); expect_z("div_ovf", 64'h0000_0000_8000_0000);
`else
    alu_run(32'h22, 32'h24, MUL_OP, 1'b0); expect_z("mul_off", 64'h0);
    alu_run(32'h24, 32'h22, DIV_OP, 1'b0); expect_z("div_off", 64'h0);
`endif

    // Bus priority with known register contents
    alu_run(32'h1234, 32'h1, ADD_OP, 1'b0);
    put_mdr(32'hAAAA_0001); mdr_out = 1; hi_in = 1; tick();
    put_mdr(32'h5555_0002); mdr_out = 1; lo_in = 1; tick();
    put_mdr(32'h0BAD_0BAD);
    #1 check("bus_idle_loaded", bus_data, 32'h0);
    gpr_out = 16'h0004; mdr_out = 1;
    #1 check("prio_r2_over_mdr", bus_data, 32'h22); idle();
    gpr_out = 16'h0014;
    #1 check("prio_r2_over_r4", bus_data, 32'h22); idle();
    gpr_out = 16'h0030;
    #1 check("prio_r4_over_r5", bus_data, 32'h24); idle();
    gpr_out = 16'h0010; hi_out = 1;
    #1 check("prio_r4_over_hi", bus_data, 32'h24); idle();
    hi_out = 1; lo_out = 1;
    #1 check("prio_hi_over_lo", bus_data, 32'hAAAA_0001); idle();
    lo_out = 1; z_high_out = 1; z_low_out = 1;
    #1 check("prio_lo_over_z", bus_data, 32'h5555_0002); idle();
    z_high_out = 1; z_low_out = 1;
    #1 check("prio_zhigh_over_zlow", bus_data, 32'h0); idle();
    z_low_out = 1; pc_out = 1;
    #1 check("prio_zlow_over_pc", bus_data, 32'h1235); idle();
    pc_out = 1; mdr_out = 1;
    #1 check("prio_pc_over_mdr", bus_data, 32'h2); idle();
    mdr_out = 1; inport_out = 1; c_out = 1;
    #1 check("prio_mdr_over_inport", bus_data, 32'h0BAD_0BAD); idle();
    inport_out = 1; c_out = 1;
    #1 check("prio_inport_over_c", bus_data, 32'h0); idle();

    // Drive and load MDR in the same cycle
    mdr_out = 1; mdr_in = 1; read = 1; m_data_in = 32'h1357_9BDF;
    #1 check("same_cycle_old_value", bus_data, 32'h0BAD_0BAD);
    tick(); idle();
    mdr_out = 1;
    #1 check("same_cycle_new_value", bus_data, 32'h1357_9BDF); idle();

    // Async reset mid-sequence, asserted away from the clock edge
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    gpr_out[2] = 1'b1; #1 check("async_rst_r2", bus_data, 32'h0); idle();
    gpr_out[5] = 1'b1; #1 check("async_rst_r5", bus_data, 32'h0); idle();
    hi_out = 1;        #1 check("async_rst_hi", bus_data, 32'h0); idle();
    lo_out = 1;        #1 check("async_rst_lo", bus_data, 32'h0); idle();
    z_low_out = 1;     #1 check("async_rst_zlo", bus_data, 32'h0); idle();
    pc_out = 1;        #1 check("async_rst_pc", bus_data, 32'h0); idle();
    mdr_out = 1;       #1 check("async_rst_mdr", bus_data, 32'h0); idle();
    c_out = 1;         #1 check("async_rst_c", bus_data, 32'h0); idle();
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath: 16 GPRs, HI, LO, PC, IR, Y, Z (64-bit), MAR, MDR, input-port register, sign-extended C constant and ALU, all sharing one internal bus.
- Sequenced externally by a control unit (or bench) through one-hot out-enables, in-enables and an ALU opcode.
- The bus is exported for observation.

Parameters:
- None. Data width is fixed at 32; GPR count is fixed at 16.

Ports:
- clk  in  1  system clock; all register loads occur on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- gpr_in  in  16  bit i loads R[i] from bus.
- gpr_out  in  16  bit i drives R[i] onto bus.
- hi_in / lo_in  in  1  load HI / LO from bus.
- hi_out / lo_out  in  1  drive HI / LO onto bus.
- pc_in / pc_out  in  1  load / drive PC.
- ir_in  in  1  load IR from bus.
- z_in  in  1  load 64-bit Z from the ALU result.
- z_high_out / z_low_out  in  1  drive Z[63:32] / Z[31:0] onto bus.
- inport_out  in  1  drive input-port register onto bus.
- c_out  in  1  drive sign-extended IR[18:0] onto bus.
- y_in  in  1  load Y from bus.
- mar_in  in  1  load MAR from bus.
- mdr_in / mdr_out  in  1  load / drive MDR.
- read  in  1  MDR source select: 1 = m_data_in, 0 = bus.
- m_data_in  in  32  memory read data.
- alu_op  in  4  ALU operation.
- inc_pc  in  1  forces the ALU result to bus+1.
- bus_data  out  32  current bus value.

Behaviour:
- Reset (async, reset_n=0): every register clears to 0, including R0–R15, HI, LO, PC, IR, Y, Z, MAR, MDR and the input port. bus_data is combinational and follows from these values.
- Register loads: a register loads on a rising clk edge when its in-enable is 1; otherwise it holds. One-cycle latency from enable to visible value.
- R0 is an ordinary register.
- MDR loads m_data_in when read=1, otherwise bus_data.
- Bus is combinational. Fixed priority when several out-enables are asserted: R0..R15 (lowest index first), HI, LO, Z_high, Z_low, PC, MDR, InPort, C. No enable asserted gives 0.
- C value: {13{IR[18]}, IR[18:0]}.
- Input port register has no load path in this revision and stays 0.
- MAR is internal only.
- ALU operands: A = Y, B = bus_data. Result is 64-bit; non-Mul/Div ops are 32-bit, zero-extended into Z.
- alu_op encoding:
  - 0000 And: A&B
  - 0001 Or: A|B
  - 0010 Add: A+B
  - 0011 Sub: A−B
  - 0100 Shr: A logical right shift by B[4:0]
  - 0101 Shl: A left shift by B[4:0]
  - 0110 Ror: A rotate right by B[4:0]
  - 0111 Rol: A rotate left by B[4:0]
  - 1000 Mul: signed A×B, full 64 bits
  - 1001 Div: signed A÷B; Z_low = quotient, Z_high = remainder (sign follows dividend)
  - 1010 Neg: −B (two's complement)
  - 1011 Not: ~B
  - 1100 Shra: A arithmetic right shift by B[4:0]
  - 1101–1111: result 0
- inc_pc=1 overrides alu_op: result = {32'b0, B+1}.
- Add/Sub wrap modulo 2^32; no carry or overflow flags.
- Div by zero: Z = 0.
- Div of 0x80000000 by −1: quotient 0x80000000, remainder 0.
- Shift by 0 returns A unchanged.
- Simultaneous load and drive of the same register in one cycle: the bus shows the old value, and the register captures the bus (or ALU) value at the edge.

Optional Feature:
- Macro DATAPATH_MULDIV_EN.
- Defined: Mul and Div implemented as specified.
- Undefined: opcodes 1000/1001 produce Z = 0 and no multiplier/divider logic is synthesized.

Test Plan:
- Reset then MDR load/transfer: m_data_in=0x22, read=1, mdr_in=1; next cycle mdr_out=1, gpr_in[2]=1 → R2=0x22. Repeat for R4=0x24 and R5=0xFF.
- PC increment: pc_out=1, mar_in=1, inc_pc=1, z_in=1, alu_op=Add with PC=0 → Z_low=1. Next cycle z_low_out=1, pc_in=1 → PC=1. Same cycle read=1, mdr_in=1, m_data_in=0x82900000 → MDR=0x82900000. Then mdr_out=1, ir_in=1 → IR=0x82900000.
- Neg: gpr_out[2]=1 (R2=0x22), alu_op=Neg, z_in=1 → Z_low=0xFFFFFFDE. Then z_low_out=1, gpr_in[5]=1 → R5=0xFFFFFFDE, bus_data shows 0xFFFFFFDE during transfer.
- Mul/Div (macro defined): Y=0x22, bus=R4=0x24 → Mul gives Z=0x4C8. Y=0x24, bus=0x22 → Div gives Z_low=1, Z_high=2. Div by 0 gives Z=0.
- Shifts/logic with Y=0x80000001, B=1:
  - Shr → 0x40000000
  - Shra → 0xC0000000
  - Ror → 0xC0000000
  - Rol → 0x00000003
  - Not of 0 → 0xFFFFFFFF
- Bus idle and priority: no out-enables → bus_data=0. With gpr_out[2] and mdr_out both set → bus shows R2. Async reset mid-sequence clears every register to 0 immediately.
